// File: rtl/mem_access_stage.sv
// Memory-access stage: EX/MEM and MEM/WB pipeline registers around a synchronous
// byte-lane data RAM, with RV32I load/store formatting, fault detection and load-use hazard.
module mem_access_stage #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_bubble,
  input  logic        flush,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_ram_address,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_load_type,
  input  logic [2:0]  ex_store_type,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  output logic [31:0] ex_mem_result_reg,
  output logic [4:0]  ex_mem_rd,
  output logic        ex_mem_reg_write_reg,
  output logic        load_use_hazard,
  output logic [31:0] mem_wb_result,
  output logic [4:0]  mem_wb_rd,
  output logic        mem_wb_reg_write,
  output logic        mem_wb_is_load,
  output logic        mem_fault
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // ---------------- EX/MEM register ----------------
  logic          exm_valid_q, exm_valid_d;
  logic [31:0]   exm_result_q;
  logic [AW+1:0] exm_addr_q;
  logic [31:0]   exm_store_data_q;
  logic [4:0]    exm_rd_q;
  logic          exm_reg_write_q;
  logic          exm_is_load_q;
  logic          exm_is_store_q;
  logic [2:0]    exm_load_type_q;
  logic [2:0]    exm_store_type_q;

  // Address bits above the RAM index wrap and are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ex_ram_address[31:AW+2];

  assign exm_valid_d = ex_valid & ~flush & ~ex_bubble;

  always_ff @(posedge clk) begin
    if (reset) begin
      exm_valid_q      <= 1'b0;
      exm_result_q     <= '0;
      exm_addr_q       <= '0;
      exm_store_data_q <= '0;
      exm_rd_q         <= '0;
      exm_reg_write_q  <= 1'b0;
      exm_is_load_q    <= 1'b0;
      exm_is_store_q   <= 1'b0;
      exm_load_type_q  <= '0;
      exm_store_type_q <= '0;
    end else begin
      exm_valid_q      <= exm_valid_d;
      exm_result_q     <= ex_result;
      exm_addr_q       <= ex_ram_address[AW+1:0];
      exm_store_data_q <= ex_store_data;
      exm_rd_q         <= ex_rd;
      exm_reg_write_q  <= ex_reg_write;
      exm_is_load_q    <= ex_is_load;
      exm_is_store_q   <= ex_is_store;
      exm_load_type_q  <= ex_load_type;
      exm_store_type_q <= ex_store_type;
    end
  end

  assign ex_mem_result_reg    = exm_result_q;
  assign ex_mem_rd            = exm_rd_q;
  assign ex_mem_reg_write_reg = exm_valid_q & exm_reg_write_q & ~exm_is_load_q;

  assign load_use_hazard = exm_valid_q & exm_is_load_q & (exm_rd_q != 5'd0) &
                           ((exm_rd_q == id_rs1_addr) | (exm_rd_q == id_rs2_addr));

  // ---------------- legality / alignment / lane steering ----------------
  logic        ld_ok;
  logic        st_ok;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [1:0]  byte_off;

  assign byte_off = exm_addr_q[1:0];

  always_comb begin
    ld_ok = 1'b0;
    unique case (exm_load_type_q)
      F3_B, F3_BU: ld_ok = 1'b1;
      F3_H, F3_HU: ld_ok = ~byte_off[0];
      F3_W:        ld_ok = (byte_off == 2'b00);
      default:     ld_ok = 1'b0;
    endcase
  end

  always_comb begin
    st_ok    = 1'b0;
    st_be    = 4'b0000;
    st_wdata = exm_store_data_q;
    unique case (exm_store_type_q)
      F3_B: begin
        st_ok    = 1'b1;
        st_be    = 4'b0001 << byte_off;
        st_wdata = {4{exm_store_data_q[7:0]}};
      end
      F3_H: begin
        st_ok    = ~byte_off[0];
        st_be    = byte_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{exm_store_data_q[15:0]}};
      end
      F3_W: begin
        st_ok    = (byte_off == 2'b00);
        st_be    = 4'b1111;
        st_wdata = exm_store_data_q;
      end
      default: begin
        st_ok = 1'b0;
        st_be = 4'b0000;
      end
    endcase
  end

  logic acc_fault;
  logic st_en;

  assign acc_fault = exm_valid_q & ((exm_is_load_q & ~ld_ok) | (exm_is_store_q & ~st_ok));
  // Reset in the store's EX/MEM cycle suppresses the write.
  assign st_en     = exm_valid_q & exm_is_store_q & st_ok & ~reset;

  // ---------------- data RAM (not reset) ----------------
  logic [31:0]   ram_q [DEPTH_WORDS];
  logic [31:0]   rdata_q;
  logic [AW-1:0] word_idx;

  assign word_idx = exm_addr_q[AW+1:2];

  always_ff @(posedge clk) begin
    if (st_en) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) ram_q[word_idx][i*8 +: 8] <= st_wdata[i*8 +: 8];
      end
    end
    rdata_q <= ram_q[word_idx];
  end

  // ---------------- MEM/WB register ----------------
  logic        mwb_reg_write_q, mwb_reg_write_d;
  logic        mwb_is_load_q, mwb_is_load_d;
  logic        mwb_fault_q, mwb_fault_d;
  logic [31:0] mwb_result_q, mwb_result_d;
  logic [4:0]  mwb_rd_q;
  logic [1:0]  mwb_off_q;
  logic [2:0]  mwb_load_type_q;

  assign mwb_reg_write_d = exm_valid_q & exm_reg_write_q & ~acc_fault & (exm_rd_q != 5'd0);
  assign mwb_is_load_d   = exm_valid_q & exm_is_load_q & ~acc_fault;
  assign mwb_fault_d     = acc_fault;
  assign mwb_result_d    = acc_fault ? 32'd0 : exm_result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mwb_reg_write_q <= 1'b0;
      mwb_is_load_q   <= 1'b0;
      mwb_fault_q     <= 1'b0;
      mwb_result_q    <= '0;
      mwb_rd_q        <= '0;
      mwb_off_q       <= '0;
      mwb_load_type_q <= '0;
    end else begin
      mwb_reg_write_q <= mwb_reg_write_d;
      mwb_is_load_q   <= mwb_is_load_d;
      mwb_fault_q     <= mwb_fault_d;
      mwb_result_q    <= mwb_result_d;
      mwb_rd_q        <= exm_rd_q;
      mwb_off_q       <= byte_off;
      mwb_load_type_q <= exm_load_type_q;
    end
  end

  // ---------------- load data formatting ----------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = rdata_q[7:0];
    unique case (mwb_off_q)
      2'd0: ld_byte = rdata_q[7:0];
      2'd1: ld_byte = rdata_q[15:8];
      2'd2: ld_byte = rdata_q[23:16];
      2'd3: ld_byte = rdata_q[31:24];
      default: ld_byte = rdata_q[7:0];
    endcase
  end

  assign ld_half = mwb_off_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    ld_data = 32'd0;
    unique case (mwb_load_type_q)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_data = rdata_q;
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
  end

  assign mem_wb_result    = mwb_is_load_q ? ld_data : mwb_result_q;
  assign mem_wb_rd        = mwb_rd_q;
  assign mem_wb_reg_write = mwb_reg_write_q;
  assign mem_wb_is_load   = mwb_is_load_q;
  assign mem_fault        = mwb_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed loads/stores push expected writebacks,
// a negedge monitor pops and compares whenever writeback or fault is presented.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_bubble, flush;
  logic [31:0] ex_result, ex_ram_address, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_is_load, ex_is_store;
  logic [2:0]  ex_load_type, ex_store_type;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic [31:0] ex_mem_result_reg;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_reg_write_reg, load_use_hazard;
  logic [31:0] mem_wb_result;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_reg_write, mem_wb_is_load, mem_fault;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_bubble(ex_bubble), .flush(flush),
    .ex_result(ex_result), .ex_ram_address(ex_ram_address), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_load_type(ex_load_type), .ex_store_type(ex_store_type),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_mem_result_reg(ex_mem_result_reg), .ex_mem_rd(ex_mem_rd),
    .ex_mem_reg_write_reg(ex_mem_reg_write_reg), .load_use_hazard(load_use_hazard),
    .mem_wb_result(mem_wb_result), .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .mem_wb_is_load(mem_wb_is_load), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        il;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wb_reg_write === 1'b1 || mem_fault === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: got rd=%0d result=%h fault=%b with nothing expected",
                 mem_wb_rd, mem_wb_result, mem_fault);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_result", mem_wb_result, e.res);
        check("wb_rd", {27'd0, mem_wb_rd}, {27'd0, e.rd});
        check("wb_reg_write", {31'd0, mem_wb_reg_write}, {31'd0, e.we});
        check("wb_fault", {31'd0, mem_fault}, {31'd0, e.flt});
        if (!e.flt) check("wb_is_load", {31'd0, mem_wb_is_load}, {31'd0, e.il});
      end
    end
  end

  task automatic push(input logic [31:0] res, input logic [4:0] rd, input logic we,
                      input logic il, input logic flt);
    exp_t e;
    e.res = res; e.rd = rd; e.we = we; e.il = il; e.flt = flt;
    sb.push_back(e);
  endtask

  task automatic issue(input logic ld, input logic st, input logic rw, input logic [2:0] ty,
                       input logic [31:0] addr, input logic [31:0] val, input logic [4:0] rd,
                       input logic fl, input logic bub);
    ex_valid = 1'b1; flush = fl; ex_bubble = bub;
    ex_is_load = ld; ex_is_store = st; ex_reg_write = rw;
    ex_load_type = ty; ex_store_type = ty;
    ex_ram_address = addr; ex_store_data = val;
    ex_result = (ld || st) ? addr : val;
    ex_rd = rd;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; flush = 1'b0; ex_bubble = 1'b0;
    ex_is_load = 1'b0; ex_is_store = 1'b0; ex_reg_write = 1'b0;
    ex_load_type = 3'd0; ex_store_type = 3'd0;
    ex_ram_address = 32'd0; ex_store_data = 32'd0; ex_result = 32'd0; ex_rd = 5'd0;
  endtask

  task automatic ld(input logic [2:0] ty, input logic [31:0] addr, input logic [4:0] rd,
                    input logic [31:0] exp);
    if (rd != 5'd0) push(exp, rd, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 1'b0, 1'b1, ty, addr, 32'd0, rd, 1'b0, 1'b0);
  endtask

  task automatic ld_fault(input logic [2:0] ty, input logic [31:0] addr, input logic [4:0] rd);
    push(32'd0, rd, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 1'b0, 1'b1, ty, addr, 32'd0, rd, 1'b0, 1'b0);
  endtask

  task automatic st(input logic [2:0] ty, input logic [31:0] addr, input logic [31:0] data);
    issue(1'b0, 1'b1, 1'b0, ty, addr, data, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic st_fault(input logic [2:0] ty, input logic [31:0] addr, input logic [31:0] data);
    push(32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 1'b0, ty, addr, data, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [31:0] res, input logic [4:0] rd);
    if (rd != 5'd0) push(res, rd, 1'b1, 1'b0, 1'b0);
    issue(1'b0, 1'b0, 1'b1, 3'd0, 32'd0, res, rd, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_exm_reg_write", {31'd0, ex_mem_reg_write_reg}, 32'd0);
    check("rst_exm_rd", {27'd0, ex_mem_rd}, 32'd0);
    check("rst_exm_result", ex_mem_result_reg, 32'd0);
    check("rst_wb_reg_write", {31'd0, mem_wb_reg_write}, 32'd0);
    check("rst_wb_is_load", {31'd0, mem_wb_is_load}, 32'd0);
    check("rst_fault", {31'd0, mem_fault}, 32'd0);
    check("rst_wb_result", mem_wb_result, 32'd0);
    check("rst_hazard", {31'd0, load_use_hazard}, 32'd0);
    reset = 1'b0;

    // store then load to the same word on consecutive cycles
    st(LW, 32'h10, 32'hDEADBEEF);
    ld(LW, 32'h10, 5'd1, 32'hDEADBEEF);
    st(LB, 32'h13, 32'h12345680);
    ld(LB, 32'h13, 5'd2, 32'hFFFFFF80);
    ld(LBU, 32'h13, 5'd3, 32'h00000080);
    ld(LW, 32'h10, 5'd4, 32'h80ADBEEF);

    // halfword lanes
    st(LW, 32'h20, 32'h55667788);
    st(LH, 32'h22, 32'hABCD1234);
    ld(LW, 32'h20, 5'd5, 32'h12347788);
    ld(LHU, 32'h22, 5'd6, 32'h00001234);
    ld(LB, 32'h21, 5'd8, 32'h00000077);
    st(LH, 32'h20, 32'hABCDF00D);
    ld(LH, 32'h20, 5'd7, 32'hFFFFF00D);
    ld(LHU, 32'h20, 5'd7, 32'h0000F00D);
    ld(LBU, 32'h20, 5'd7, 32'h0000000D);
    ld(LW, 32'h1020, 5'd7, 32'h1234F00D);

    // faults: misaligned and illegal types leave RAM untouched
    st(LW, 32'h00, 32'hA5A5A5A5);
    st_fault(LH, 32'h01, 32'h0000FFFF);
    ld(LW, 32'h00, 5'd10, 32'hA5A5A5A5);
    ld_fault(LW, 32'h06, 5'd9);
    idle(); @(posedge clk); #1;
    ld_fault(LH, 32'h03, 5'd9);
    ld_fault(3'b011, 32'h20, 5'd11);
    ld_fault(3'b110, 32'h20, 5'd11);
    st_fault(3'b011, 32'h00, 32'h00000000);
    st_fault(LW, 32'h02, 32'h00000000);
    ld(LW, 32'h00, 5'd10, 32'hA5A5A5A5);
    st(LB, 32'h01, 32'h0000003C);
    ld(LW, 32'h00, 5'd10, 32'hA5A53CA5);

    // non-load writeback and forwarding view
    alu(32'h0BADF00D, 5'd12);
    check("fwd_reg_write", {31'd0, ex_mem_reg_write_reg}, 32'd1);
    check("fwd_result", ex_mem_result_reg, 32'h0BADF00D);
    check("fwd_rd", {27'd0, ex_mem_rd}, 32'd12);
    alu(32'h00000042, 5'd0);

    // load-use hazard
    ld(LW, 32'h10, 5'd5, 32'h80ADBEEF);
    check("fwd_load_no_reg_write", {31'd0, ex_mem_reg_write_reg}, 32'd0);
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd5; #1;
    check("hazard_rs2", {31'd0, load_use_hazard}, 32'd1);
    id_rs1_addr = 5'd7; id_rs2_addr = 5'd6; #1;
    check("hazard_none", {31'd0, load_use_hazard}, 32'd0);
    id_rs1_addr = 5'd5; #1;
    check("hazard_rs1", {31'd0, load_use_hazard}, 32'd1);
    ld(LW, 32'h10, 5'd0, 32'h0);
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; #1;
    check("hazard_rd0", {31'd0, load_use_hazard}, 32'd0);

    // flushed / bubbled slots never write
    st(LW, 32'h30, 32'h22222222);
    issue(1'b0, 1'b1, 1'b0, LW, 32'h30, 32'h11111111, 5'd0, 1'b1, 1'b0);
    issue(1'b0, 1'b1, 1'b0, LW, 32'h30, 32'h33333333, 5'd0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 1'b1, LW, 32'h30, 32'h0, 5'd13, 1'b1, 1'b0);
    issue(1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h99, 5'd13, 1'b0, 1'b1);
    ld(LW, 32'h30, 5'd13, 32'h22222222);

    // reset while a store sits in EX/MEM; capture attempted in the same cycle
    st(LW, 32'h30, 32'h44444444);
    reset = 1'b1;
    id_rs1_addr = 5'd17;
    issue(1'b1, 1'b0, 1'b1, LW, 32'h30, 32'h0, 5'd17, 1'b0, 1'b0);
    check("rstmid_exm_reg_write", {31'd0, ex_mem_reg_write_reg}, 32'd0);
    check("rstmid_hazard", {31'd0, load_use_hazard}, 32'd0);
    check("rstmid_wb_reg_write", {31'd0, mem_wb_reg_write}, 32'd0);
    check("rstmid_fault", {31'd0, mem_fault}, 32'd0);
    check("rstmid_wb_is_load", {31'd0, mem_wb_is_load}, 32'd0);
    reset = 1'b0;
    id_rs1_addr = 5'd0;
    ld(LW, 32'h30, 5'd16, 32'h22222222);

    idle();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending writebacks expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Holds the EX/MEM and MEM/WB pipeline registers and the synchronous data RAM.
- Performs RV32I loads and stores: byte/half/word, sign- or zero-extension, alignment checking.
- Produces the forwarding values and writeback bundle consumed by execute and decode, plus a load-use hazard flag for upstream stall.

Parameters:
DEPTH_WORDS, 1024, data RAM depth in 32-bit words (power of two).
AW, $clog2(DEPTH_WORDS), word-index width; byte address bits [AW+1:2] select the word, higher bits ignored (wrap).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
ex_valid  in  1  execute output holds a real instruction
ex_bubble  in  1  insert bubble into EX/MEM (divider busy)
flush  in  1  kill instruction entering EX/MEM
ex_result  in  32  ALU/div/link result
ex_ram_address  in  32  byte address for load/store
ex_store_data  in  32  forwarded rs2 value
ex_rd  in  5  destination register
ex_reg_write  in  1  instruction writes rd
ex_is_load  in  1  load instruction
ex_is_store  in  1  store instruction
ex_load_type  in  3  funct3 of load
ex_store_type  in  3  funct3 of store
id_rs1_addr  in  5  rs1 of instruction in decode
id_rs2_addr  in  5  rs2 of instruction in decode
ex_mem_result_reg  out  32  EX/MEM result (forwarding)
ex_mem_rd  out  5  EX/MEM rd
ex_mem_reg_write_reg  out  1  EX/MEM valid & reg_write & !is_load
load_use_hazard  out  1  stall request to fetch/decode
mem_wb_result  out  32  final writeback data (load data or result)
mem_wb_rd  out  5  writeback rd
mem_wb_reg_write  out  1  writeback enable
mem_wb_is_load  out  1  writeback data came from RAM
mem_fault  out  1  one-cycle pulse: misaligned or illegal-type access in MEM/WB

Behaviour:
- Reset: all valid/reg_write/is_load/fault bits 0; results, rd, address regs 0. RAM contents are not cleared. Reset overrides flush and bubble.
- EX/MEM capture at each posedge: valid <= ex_valid & !flush & !ex_bubble. Other fields are captured unconditionally; they are don't-care when valid=0.
- Priority: reset > flush > bubble > capture.
- Store: occurs in the EX/MEM cycle when valid & is_store & legal & aligned.
  - SB (000): write byte lane addr[1:0] with data[7:0].
  - SH (001): write lanes {addr[1],0}/+1 with data[15:0].
  - SW (010): write all four lanes.
  - Other lanes untouched.
- Load: RAM is read synchronously using the EX/MEM address. Data is valid in the MEM/WB cycle (1-cycle latency). Byte offset and load_type are registered alongside the read for formatting.
  - LB 000: sign-extend byte at offset.
  - LH 001: sign-extend half at offset[1].
  - LW 010: full word.
  - LBU 100: zero-extend byte.
  - LHU 101: zero-extend half.
- Legality and alignment:
  - Load types 011, 110, 111 and store types 011–111 are illegal.
  - Half accesses with addr[0]=1 are misaligned.
  - Word accesses with addr[1:0]≠0 are misaligned.
  - On a fault: no RAM write, mem_wb_reg_write=0, mem_wb_result=0, mem_fault=1 for exactly one cycle.
- MEM/WB fields:
  - mem_wb_reg_write = valid & reg_write & !fault & (rd≠0).
  - mem_wb_result = formatted load data if is_load, else the registered result.
- load_use_hazard (combinational) = EX/MEM valid & is_load & rd≠0 & (rd==id_rs1_addr | rd==id_rs2_addr).
- Store followed by load to the same word in the next cycle: the load returns the newly written data (write precedes read one cycle later). No bypass is needed.
- A flushed or bubbled slot never writes RAM and never asserts reg_write or fault.
- Reset asserted mid-operation: any in-flight store in EX/MEM that cycle does not write. Pipeline valids clear next edge.
- Throughput: one instruction per cycle; no internal stalls.

Test Plan:
- SW 0xDEADBEEF to 0x10, then LW 0x10 next cycle -> MEM/WB one cycle later: result 0xDEADBEEF, reg_write=1, is_load=1.
- SB 0x80 to 0x13, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
- SH 0x1234 to 0x22 -> LW 0x20 returns 0x1234xxxx with the low half unchanged; LHU 0x22 -> 0x00001234.
- LW at 0x06 or SH at 0x01 -> mem_fault pulses one cycle, reg_write=0, RAM unchanged (re-read confirms).
- LW rd=5 in EX/MEM with id_rs2_addr=5 -> load_use_hazard=1. Same load with rd=0 -> hazard=0.
- SW with flush=1 (or ex_bubble=1) at capture -> no write. Reset during a valid SW in EX/MEM -> no write, all valids 0 next cycle.
